// File: rtl/clk_div_mon_pkg.sv
// Shared types and constants for the divided-clock monitor.
package clk_div_mon_pkg;

  // Monitor FSM encoding
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StMeas   = 2'd1,
    StLocked = 2'd2
  } mon_state_e;

  // Width of the consecutive-match counter; bounds LOCK_CNT to 1..15
  localparam int unsigned MatchCntW = 4;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous level and flags its edges. The rise/fall
// outputs are combinational on the synchronized level versus its history flop
// so the parent can register them and act on them in the same edge.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Synchronizer chain followed by one history flop
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d_i};
      r_hist <= w_sync;
    end
  end

  assign rise_o = w_sync & ~r_hist;
  assign fall_o = ~w_sync & r_hist;

endmodule

// File: rtl/clk_div_monitor.sv
// Samples a divided clock as data, emits rise/fall enables, measures the
// rise-to-rise period and locks once it repeatedly matches the expected ratio.
module clk_div_monitor
  import clk_div_mon_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned EXP_PERIOD  = 4,
  parameter int unsigned TOL         = 0,
  parameter int unsigned LOCK_CNT    = 4
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             div_clk_i,
  input  logic             err_clr_i,
  output logic             rise_pulse_o,
  output logic             fall_pulse_o,
  output logic [CNT_W-1:0] period_o,
  output logic             locked_o,
  output logic             err_o
);

  localparam int unsigned LoInt = (EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0;
  localparam logic [CNT_W-1:0]     PerLo = CNT_W'(LoInt);
  localparam logic [CNT_W-1:0]     PerHi = CNT_W'(EXP_PERIOD + TOL);
  // A counter reaching one past the upper bound can no longer yield a match
  localparam logic [CNT_W-1:0]     TmoCnt = CNT_W'(EXP_PERIOD + TOL + 1);
  localparam logic [CNT_W-1:0]     CntMax = '1;
  localparam logic [MatchCntW-1:0] LockC  = MatchCntW'(LOCK_CNT);

  logic                 w_rise;
  logic                 w_fall;
  logic                 w_match;
  logic                 w_timeout;
  logic [MatchCntW-1:0] w_match_inc;

  logic                 r_rise;
  logic                 r_fall;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     r_period;
  logic [MatchCntW-1:0] r_match_cnt;
  logic                 r_locked;
  logic                 r_err;
  mon_state_e           r_state;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .d_i   (div_clk_i),
    .rise_o(w_rise),
    .fall_o(w_fall)
  );

  assign w_match     = (r_cnt >= PerLo) && (r_cnt <= PerHi);
  assign w_timeout   = !w_rise && (r_cnt == TmoCnt);
  assign w_match_inc = r_match_cnt + MatchCntW'(1);

  // Registered edge pulses and saturating rise-to-rise period counter
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_rise <= w_rise;
      r_fall <= w_fall;
      if (w_rise) begin
        r_cnt <= CNT_W'(1);
      end else if (r_cnt != CntMax) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Lock FSM with registered period, lock and sticky error outputs
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_match_cnt <= '0;
      r_period    <= '0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // A set from the case below overrides this clear in the same cycle
      if (err_clr_i) begin
        r_err <= 1'b0;
      end
      unique case (r_state)
        StIdle: begin
          // First rise only arms the measurement; nothing to capture yet
          if (w_rise) begin
            r_state     <= StMeas;
            r_match_cnt <= '0;
          end
        end
        StMeas: begin
          if (w_rise) begin
            r_period <= r_cnt;
            if (w_match) begin
              r_match_cnt <= w_match_inc;
              if (w_match_inc == LockC) begin
                r_state  <= StLocked;
                r_locked <= 1'b1;
              end
            end else begin
              r_match_cnt <= '0;
            end
          end else if (w_timeout) begin
            r_state     <= StIdle;
            r_match_cnt <= '0;
          end
        end
        StLocked: begin
          if (w_rise) begin
            r_period <= r_cnt;
            if (!w_match) begin
              r_state     <= StMeas;
              r_match_cnt <= '0;
              r_locked    <= 1'b0;
              r_err       <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state     <= StIdle;
            r_match_cnt <= '0;
            r_locked    <= 1'b0;
            r_err       <= 1'b1;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_match_cnt <= '0;
          r_locked    <= 1'b0;
        end
      endcase
    end
  end

  assign rise_pulse_o = r_rise;
  assign fall_pulse_o = r_fall;
  assign period_o     = r_period;
  assign locked_o     = r_locked;
  assign err_o        = r_err;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: two instances (TOL=0 and TOL=1) compared every
// cycle against an edge-index reference model, plus directed end-of-step checks.
module tb_clk_div_monitor;

  localparam int S   = 2;
  localparam int EXP = 4;
  localparam int LK  = 4;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       d0;
  logic       d1;
  logic       rise_s [2];
  logic       fall_s [2];
  logic       lock_s [2];
  logic       err_s  [2];
  logic [7:0] per_s  [2];

  int checks = 0;
  int errors = 0;
  int n      = 0;

  // Reference model state: sample history per instance plus lock bookkeeping
  bit mq       [2][0:S];
  bit m_armed  [2];
  bit m_locked [2];
  bit m_err    [2];
  bit m_rise   [2];
  bit m_fall   [2];
  int m_period [2];
  int m_mcnt   [2];
  int m_last   [2];

  clk_div_monitor #(
    .SYNC_STAGES(S), .CNT_W(8), .EXP_PERIOD(EXP), .TOL(0), .LOCK_CNT(LK)
  ) u_dut0 (
    .clk_i(clk), .rst_n(rst_n), .div_clk_i(d0), .err_clr_i(clr),
    .rise_pulse_o(rise_s[0]), .fall_pulse_o(fall_s[0]), .period_o(per_s[0]),
    .locked_o(lock_s[0]), .err_o(err_s[0])
  );

  clk_div_monitor #(
    .SYNC_STAGES(S), .CNT_W(8), .EXP_PERIOD(EXP), .TOL(1), .LOCK_CNT(LK)
  ) u_dut1 (
    .clk_i(clk), .rst_n(rst_n), .div_clk_i(d1), .err_clr_i(clr),
    .rise_pulse_o(rise_s[1]), .fall_pulse_o(fall_s[1]), .period_o(per_s[1]),
    .locked_o(lock_s[1]), .err_o(err_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cycle %0d observed %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  // One clock edge of the model: edges are seen S samples late, periods are
  // distances between rise-processing edges, and lock follows the match rules.
  task automatic model_edge(input int i, input logic dv, input logic c, input logic r,
                            input int tol);
    bit rs, fl, se;
    int age;
    if (!r) begin
      for (int k = 0; k <= S; k++) mq[i][k] = 1'b0;
      m_armed[i] = 0; m_locked[i] = 0; m_err[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
      m_period[i] = 0; m_mcnt[i] = 0;
      return;
    end
    rs = mq[i][S-1] && !mq[i][S];
    fl = !mq[i][S-1] && mq[i][S];
    for (int k = S; k > 0; k--) mq[i][k] = mq[i][k-1];
    mq[i][0] = dv;
    m_rise[i] = rs;
    m_fall[i] = fl;
    se  = 0;
    age = n - m_last[i];
    if (rs) begin
      if (m_armed[i]) begin
        m_period[i] = age;
        if (age >= EXP - tol && age <= EXP + tol) begin
          if (!m_locked[i]) begin
            m_mcnt[i]++;
            if (m_mcnt[i] == LK) m_locked[i] = 1;
          end
        end else begin
          if (m_locked[i]) se = 1;
          m_locked[i] = 0;
          m_mcnt[i]   = 0;
        end
      end else begin
        m_armed[i] = 1;
        m_mcnt[i]  = 0;
      end
      m_last[i] = n;
    end else if (m_armed[i] && age == EXP + tol + 1) begin
      if (m_locked[i]) se = 1;
      m_armed[i]  = 0;
      m_locked[i] = 0;
      m_mcnt[i]   = 0;
    end
    if (se) m_err[i] = 1;
    else if (c) m_err[i] = 0;
  endtask

  task automatic step(input logic dv0, input logic dv1, input logic c, input logic r);
    d0 = dv0; d1 = dv1; clr = c; rst_n = r;
    @(posedge clk);
    n++;
    model_edge(0, dv0, c, r, 0);
    model_edge(1, dv1, c, r, 1);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rise%0d", i), 32'(rise_s[i]), 32'(m_rise[i]));
      check($sformatf("fall%0d", i), 32'(fall_s[i]), 32'(m_fall[i]));
      check($sformatf("period%0d", i), 32'(per_s[i]), 32'(m_period[i]));
      check($sformatf("locked%0d", i), 32'(lock_s[i]), 32'(m_locked[i]));
      check($sformatf("err%0d", i), 32'(err_s[i]), 32'(m_err[i]));
    end
  endtask

  // One divided-clock period on instance idx; bit k of mask pulses err_clr on step k
  task automatic wave(input int idx, input int hi, input int lo, input int mask);
    logic dv, c;
    for (int k = 0; k < hi + lo; k++) begin
      dv = (k < hi);
      c  = ((mask >> k) & 1) != 0;
      if (idx == 0) step(dv, 1'b0, c, 1'b1);
      else          step(1'b0, dv, c, 1'b1);
    end
  endtask

  initial begin
    // Reset held 3 cycles with the divided clock toggling
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("rst_period", 32'(per_s[0]), 32'd0);
    check("rst_locked", 32'(lock_s[0]), 32'd0);
    check("rst_err", 32'(err_s[0]), 32'd0);

    // Ideal /4: arm plus 4 matches locks on the 5th rise
    for (int w = 0; w < 6; w++) wave(0, 2, 2, 0);
    check("ideal_locked", 32'(lock_s[0]), 32'd1);
    check("ideal_period", 32'(per_s[0]), 32'd4);
    check("ideal_err", 32'(err_s[0]), 32'd0);

    // Stretched period times out, then relock with err still sticky
    wave(0, 3, 3, 0);
    for (int w = 0; w < 5; w++) wave(0, 2, 2, 0);
    check("relock_locked", 32'(lock_s[0]), 32'd1);
    check("relock_err", 32'(err_s[0]), 32'd1);

    // Clearing err
    wave(0, 2, 2, 1);
    check("clr_err", 32'(err_s[0]), 32'd0);
    check("clr_locked", 32'(lock_s[0]), 32'd1);

    // Short period while locked, clear coincides with the set: set wins
    wave(0, 1, 2, 0);
    wave(0, 2, 2, 4);
    check("setwin_err", 32'(err_s[0]), 32'd1);
    check("setwin_locked", 32'(lock_s[0]), 32'd0);
    check("setwin_period", 32'(per_s[0]), 32'd3);
    wave(0, 2, 2, 1);
    check("clr2_err", 32'(err_s[0]), 32'd0);

    // Relock, then stop the divided clock: timeout keeps last period
    for (int w = 0; w < 4; w++) wave(0, 2, 2, 0);
    check("pre_tmo_locked", 32'(lock_s[0]), 32'd1);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("tmo_locked", 32'(lock_s[0]), 32'd0);
    check("tmo_err", 32'(err_s[0]), 32'd1);
    check("tmo_period", 32'(per_s[0]), 32'd4);

    // TOL=1: periods 3,5,4,3 lock, then a period of 6 mismatches
    wave(1, 1, 2, 0);
    wave(1, 2, 3, 0);
    wave(1, 2, 2, 0);
    wave(1, 1, 2, 0);
    wave(1, 3, 3, 0);
    check("tol_locked", 32'(lock_s[1]), 32'd1);
    check("tol_period", 32'(per_s[1]), 32'd3);
    wave(1, 2, 2, 0);
    check("tol_mm_locked", 32'(lock_s[1]), 32'd0);
    check("tol_mm_err", 32'(err_s[1]), 32'd1);
    check("tol_mm_period", 32'(per_s[1]), 32'd6);

    // Randomized periods, mostly nominal, with stray clears and a mid-run reset
    for (int w = 0; w < 60; w++) begin
      int p, h, m;
      p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 7)) : 4;
      h = int'($urandom_range(1, p - 1));
      m = ($urandom_range(0, 7) == 0) ? (1 << $urandom_range(0, p - 1)) : 0;
      wave((w < 30) ? 0 : 1, h, p - h, m);
      if (w == 20) begin
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
